// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode stage of the 5-stage pipeline with an internal ID/EX register.
//   Control decode, sign extension, register file with optional same-cycle write-back
//   bypass, load-use stall detection and branch flush.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   instr_in, npc_in  instruction and PC+4 from IF/ID; valid_in marks a real instruction
//   flush_in          squash the instruction currently in ID
//   wb_regwrite, wb_addr, wb_data  register-file write-back port
//   stall_out         combinational load-use stall request (hold PC and IF/ID)
//   valid_out ... rd_out           registered ID/EX fields
module id_stage_pipelined #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NREG      = 32,
   parameter int unsigned WB_BYPASS = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [31:0]              instr_in,
   input  logic [XLEN-1:0]          npc_in,
   input  logic                     valid_in,
   input  logic                     flush_in,
   input  logic                     wb_regwrite,
   input  logic [$clog2(NREG)-1:0]  wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   output logic                     stall_out,
   output logic                     valid_out,
   output logic                     branch_eq_out,
   output logic                     branch_ne_out,
   output logic                     jump_out,
   output logic                     alusrc_out,
   output logic                     memread_out,
   output logic                     memwrite_out,
   output logic                     regwrite_out,
   output logic                     regdst_out,
   output logic                     memtoreg_out,
   output logic [1:0]               aluop_out,
   output logic [XLEN-1:0]          npc_out,
   output logic [XLEN-1:0]          rdata1_out,
   output logic [XLEN-1:0]          rdata2_out,
   output logic [XLEN-1:0]          imm_out,
   output logic [$clog2(NREG)-1:0]  rs_out,
   output logic [$clog2(NREG)-1:0]  rt_out,
   output logic [$clog2(NREG)-1:0]  rd_out
);

   localparam int unsigned AW = $clog2(NREG);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef struct packed {
      logic       branch_eq;
      logic       branch_ne;
      logic       jump;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] aluop;
   } ctrl_t;

   logic [5:0]      opcode;
   logic [AW-1:0]   rs;
   logic [AW-1:0]   rt;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] imm;
   ctrl_t           dec;
   logic            uses_rt;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic [XLEN-1:0] regs [NREG];
   ctrl_t           ctrl_q;

   assign opcode = instr_in[31:26];
   assign rs     = instr_in[21 +: AW];
   assign rt     = instr_in[16 +: AW];
   assign rd     = instr_in[11 +: AW];
   assign imm    = {{(XLEN-16){instr_in[15]}}, instr_in[15:0]};

   // Control decode; unlisted opcodes fall through as NOP.
   always_comb begin
      dec     = '0;
      uses_rt = 1'b0;
      case (opcode)
         OP_R: begin
            dec.regdst   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = 2'b10;
            uses_rt      = 1'b1;
         end
         OP_LW: begin
            dec.alusrc   = 1'b1;
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_SW: begin
            dec.alusrc   = 1'b1;
            dec.memwrite = 1'b1;
            uses_rt      = 1'b1;
         end
         OP_BEQ: begin
            dec.branch_eq = 1'b1;
            dec.aluop     = 2'b01;
            uses_rt       = 1'b1;
         end
         OP_BNE: begin
            dec.branch_ne = 1'b1;
            dec.aluop     = 2'b01;
            uses_rt       = 1'b1;
         end
         OP_J: begin
            dec.jump = 1'b1;
         end
         OP_ADDI: begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
         end
         default: dec = '0;
      endcase
   end

   // Register file; entry 0 is never written so it stays zero from reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_regwrite && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Read ports, with optional forwarding of the write happening this cycle.
   always_comb begin
      rdata1 = (rs == '0) ? '0 : regs[rs];
      rdata2 = (rt == '0) ? '0 : regs[rt];
      if ((WB_BYPASS != 0) && wb_regwrite && (wb_addr != '0)) begin
         if (wb_addr == rs) rdata1 = wb_data;
         if (wb_addr == rt) rdata2 = wb_data;
      end
   end

   // Load in EX whose destination is a source of the instruction in ID.
   // A flush wins: the dependent instruction is being discarded anyway.
   assign stall_out = valid_in && valid_out && ctrl_q.memread && (rt_out != '0) &&
                      ((rt_out == rs) || (uses_rt && (rt_out == rt))) && !flush_in;

   // ID/EX register: flush and stall both insert a bubble; data fields load freely.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_out  <= 1'b0;
         ctrl_q     <= '0;
         npc_out    <= '0;
         rdata1_out <= '0;
         rdata2_out <= '0;
         imm_out    <= '0;
         rs_out     <= '0;
         rt_out     <= '0;
         rd_out     <= '0;
      end else begin
         npc_out    <= npc_in;
         rdata1_out <= rdata1;
         rdata2_out <= rdata2;
         imm_out    <= imm;
         rs_out     <= rs;
         rt_out     <= rt;
         rd_out     <= rd;
         if (flush_in || stall_out) begin
            valid_out <= 1'b0;
            ctrl_q    <= '0;
         end else begin
            valid_out <= valid_in;
            ctrl_q    <= valid_in ? dec : '0;
         end
      end
   end

   assign branch_eq_out = ctrl_q.branch_eq;
   assign branch_ne_out = ctrl_q.branch_ne;
   assign jump_out      = ctrl_q.jump;
   assign alusrc_out    = ctrl_q.alusrc;
   assign memread_out   = ctrl_q.memread;
   assign memwrite_out  = ctrl_q.memwrite;
   assign regwrite_out  = ctrl_q.regwrite;
   assign regdst_out    = ctrl_q.regdst;
   assign memtoreg_out  = ctrl_q.memtoreg;
   assign aluop_out     = ctrl_q.aluop;

endmodule
